md_sequencer: RTL and testbench
===============================

Name: md_sequencer

Overview:
- Iterative multiply/divide sequencer beside the execute-stage ALU; owns the HI/LO register pair.
- Launched from execute by MULT/MULTU/DIV/DIVU; MTHI/MTLO complete in one cycle.
- Raises busy so the hazard unit stalls the pipeline: IF, ID and EX hold while busy, and any MFHI/MFLO waits for busy to fall.
- Results are committed to HI/LO as the operation finishes.

Parameters:
- XLEN, 32, operand/result width.
- CYCLES, 32, iteration count of the multiply/divide loop; must equal XLEN.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  op request from execute, valid when op_i != MD_NONE.
- op_i  in  3  md_op_t: MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
- src_a_i  in  XLEN  rs operand (forwarded value).
- src_b_i  in  XLEN  rt operand (forwarded value).
- flush_i  in  1  abort the in-flight op.
- busy_o  out  1  high while an op is in flight.
- done_o  out  1  one-cycle pulse when HI/LO commit.
- hi_o  out  XLEN  HI register.
- lo_o  out  XLEN  LO register.

Behaviour:
- Reset (async, rst_i=0):
  - state=IDLE; busy_o=0, done_o=0, hi_o=0, lo_o=0.
  - Internal accumulator, counter and sign flags cleared.
  - Reset mid-op discards the op; outputs take reset values immediately.
- FSM states: IDLE, CALC, FIXUP.
- IDLE:
  - start_i with MULT/MULTU/DIV/DIVU: latch operand magnitudes (signed ops use absolute value), latch the result-sign flags, counter=0, go to CALC.
  - start_i with MTHI/MTLO: write src_a_i to HI/LO at the clock edge; stay in IDLE; no busy; done_o=0.
  - start_i with MD_NONE, or start_i=0: no action.
- CALC:
  - Multiply: one shift-add step per cycle on a 2*XLEN product register.
  - Divide: one restoring-division step per cycle on a remainder/quotient register pair.
  - counter increments each cycle; after CYCLES steps, go to FIXUP.
- FIXUP:
  - Apply sign correction. Signed multiply: negate the 64-bit product if the operand signs differ. Signed divide: quotient negative if the signs differ; remainder takes the dividend's sign.
  - Write HI/LO: multiply gives HI=upper half, LO=lower half; divide gives LO=quotient, HI=remainder.
  - Pulse done_o; return to IDLE.
- Timing:
  - busy_o = (state != IDLE), registered.
  - Start accepted at edge 0; busy_o high for cycles 1..CYCLES+1 (33 cycles).
  - HI/LO new values and done_o=1 are visible in the first cycle with busy_o=0.
- Division by zero (either signedness): HI=src_a_i as latched, LO=all-ones; same latency as a normal divide.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- start_i while busy: ignored. The hazard unit guarantees no issue while busy; assertion in simulation.
- flush_i:
  - Busy: return to IDLE next edge; HI/LO unchanged; no done_o.
  - Same cycle as an IDLE start: the start is suppressed, including MTHI/MTLO.
  - Coincides with FIXUP: flush wins, no commit.

Optional Feature:
- MD_FAST_MUL_EN defined:
  - MULT/MULTU use a single combinational XLEN x XLEN multiplier.
  - IDLE goes straight to FIXUP with the product latched; busy_o high for 1 cycle.
  - Divide is unchanged.
- Undefined: multiply is iterative, CYCLES+1 busy cycles.

Decomposition:
- Shared pipeline package:
  - md_op_t enum (3 bits) and md_state_t enum.
  - Constants MD_CYCLES=32 and MD_DIV0_QUOT='1.
  - The decoder and hazard unit import md_op_t.
- Sub-module md_datapath: iteration registers, shift/add/subtract step, sign fixup.
- md_sequencer keeps the FSM, counter, HI/LO and handshake.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF: busy_o high 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001, done_o pulses once.
- MULT -3 x 5: HI=0xFFFFFFFF, LO=0xFFFFFFF1. With MD_FAST_MUL_EN, same result after 1 busy cycle.
- DIV -7 / 2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- DIVU 7 / 0: HI=0x00000007, LO=0xFFFFFFFF after 33 cycles.
- MTHI 0x1234 then MTLO 0xABCD on back-to-back cycles: HI/LO update at each edge, busy_o stays 0. Then MULTU 2 x 3 with flush_i at cycle 10: busy_o falls next cycle, HI/LO remain 0x1234/0xABCD, no done_o.
- rst_i low at cycle 20 of a DIVU: all outputs 0 immediately. After release, DIVU 100 / 7 gives LO=14, HI=2.

Source files
------------

// File: rtl/md_sequencer_pkg.sv
// Shared types and constants for the multiply/divide sequencer, decoder and hazard unit.
package md_sequencer_pkg;

  localparam int MD_CYCLES = 32;
  localparam logic [MD_CYCLES-1:0] MD_DIV0_QUOT = '1;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2
  } md_state_t;

endpackage

// File: rtl/md_sequencer_if.sv
// Execute-stage request / HI-LO result bundle between the pipeline and md_sequencer.
interface md_sequencer_if
  import md_sequencer_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            start_i;
  md_op_t          op_i;
  logic [XLEN-1:0] src_a_i;
  logic [XLEN-1:0] src_b_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] hi_o;
  logic [XLEN-1:0] lo_o;

  modport master (
    output start_i, op_i, src_a_i, src_b_i, flush_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, src_a_i, src_b_i, flush_i,
    output busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/md_datapath.sv
// Iteration registers for shift-add multiply / restoring divide, plus sign fixup.
// MD_FAST_MUL_EN: multiply magnitudes are produced in one combinational step on load.
module md_datapath
  import md_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            step_i,
  input  md_op_t          op_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  output logic [XLEN-1:0] res_hi_o,
  output logic [XLEN-1:0] res_lo_o
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, a_raw_q;
  logic              div_q, neg_res_q, neg_rem_q, div0_q;

  logic              sgn_op, div_op, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
  logic [2*XLEN:0]   mul_wide;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;

  always_comb begin
    sgn_op = (op_i == MD_MULT) || (op_i == MD_DIV);
    div_op = (op_i == MD_DIV) || (op_i == MD_DIVU);
    a_neg  = sgn_op & src_a_i[XLEN-1];
    b_neg  = sgn_op & src_b_i[XLEN-1];
    a_mag  = a_neg ? -src_a_i : src_a_i;
    b_mag  = b_neg ? -src_b_i : src_b_i;

    // Multiply: LO half holds the shifting multiplier, HI half the partial sum.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    mul_wide = {mul_sum, acc_q[XLEN-1:0]};
    mul_next = mul_wide[2*XLEN:1];

    // Divide: HI half is the partial remainder, LO half shifts dividend out / quotient in.
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, opb_q};
    if (!rem_diff[XLEN]) div_next = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else                 div_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

    acc_d = acc_q;
    if (load_i) begin
      acc_d = {{XLEN{1'b0}}, a_mag};
`ifdef MD_FAST_MUL_EN
      if (!div_op) acc_d = (2*XLEN)'(a_mag) * (2*XLEN)'(b_mag);
`endif
    end else if (step_i) begin
      acc_d = div_q ? div_next : mul_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q     <= '0;
      opb_q     <= '0;
      a_raw_q   <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (load_i) begin
        opb_q     <= b_mag;
        a_raw_q   <= src_a_i;
        div_q     <= div_op;
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        div0_q    <= div_op && (src_b_i == '0);
      end
    end
  end

  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    if (div0_q) begin
      res_hi_o = a_raw_q;
      res_lo_o = XLEN'(MD_DIV0_QUOT);
    end else if (div_q) begin
      res_hi_o = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      res_lo_o = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    end else begin
      res_hi_o = prod_fix[2*XLEN-1:XLEN];
      res_lo_o = prod_fix[XLEN-1:0];
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer owning HI/LO: FSM, iteration counter and pipeline handshake.
// MD_FAST_MUL_EN: MULT/MULTU skip the iteration loop and go straight to fixup.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CYCLES = MD_CYCLES
) (
  input  logic           clk_i,
  input  logic           rst_i,
  md_sequencer_if.slave  md_if
);

  // state | meaning
  // IDLE  | waiting for an op; MTHI/MTLO handled here in one cycle
  // CALC  | one multiply/divide iteration per cycle, CYCLES total
  // FIXUP | sign correction, commit HI/LO, pulse done

  localparam int CW = $clog2(CYCLES);

  md_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, done_q;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            is_long, accept, load, step, commit, mthi_we, mtlo_we;
  logic [XLEN-1:0] res_hi, res_lo;

  assign is_long = (md_if.op_i == MD_MULT) || (md_if.op_i == MD_MULTU) ||
                   (md_if.op_i == MD_DIV)  || (md_if.op_i == MD_DIVU);
  assign accept  = (state_q == ST_IDLE) && md_if.start_i && !md_if.flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= commit;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && is_long) begin
`ifdef MD_FAST_MUL_EN
          state_d = ((md_if.op_i == MD_MULT) || (md_if.op_i == MD_MULTU)) ? ST_FIXUP : ST_CALC;
`else
          state_d = ST_CALC;
`endif
        end
      end
      ST_CALC: begin
        if (md_if.flush_i)                    state_d = ST_IDLE;
        else if (cnt_q == CW'(CYCLES - 1))    state_d = ST_FIXUP;
      end
      ST_FIXUP: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load    = accept && is_long;
    step    = (state_q == ST_CALC);
    commit  = (state_q == ST_FIXUP) && !md_if.flush_i;
    mthi_we = accept && (md_if.op_i == MD_MTHI);
    mtlo_we = accept && (md_if.op_i == MD_MTLO);
    cnt_d   = cnt_q;
    if (load)      cnt_d = '0;
    else if (step) cnt_d = cnt_q + CW'(1);
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end
    if (mthi_we) hi_d = md_if.src_a_i;
    if (mtlo_we) lo_d = md_if.src_a_i;
  end

  md_datapath #(.XLEN(XLEN)) u_datapath (
    .clk_i   (clk_i),
    .rst_ni  (rst_i),
    .load_i  (load),
    .step_i  (step),
    .op_i    (md_if.op_i),
    .src_a_i (md_if.src_a_i),
    .src_b_i (md_if.src_b_i),
    .res_hi_o(res_hi),
    .res_lo_o(res_lo)
  );

  assign md_if.busy_o = busy_q;
  assign md_if.done_o = done_q;
  assign md_if.hi_o   = hi_q;
  assign md_if.lo_o   = lo_q;

  // The hazard unit must never issue while an op is in flight.
  a_no_start_busy: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(busy_q && md_if.start_i && (md_if.op_i != MD_NONE)));

endmodule

// File: tb/tb_md_sequencer.sv
// Directed scoreboard bench for md_sequencer.
module tb_md_sequencer;
  import md_sequencer_pkg::*;

`ifdef MD_FAST_MUL_EN
  localparam int MUL_BUSY  = 1;
  localparam int FLUSH_CYC = 1;
`else
  localparam int MUL_BUSY  = 33;
  localparam int FLUSH_CYC = 10;
`endif
  localparam int DIV_BUSY = 33;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb_q[$];

  md_sequencer_if #(.XLEN(32)) bus ();

  md_sequencer #(.XLEN(32), .CYCLES(32)) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .md_if(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.src_a_i = a;
    bus.src_b_i = b;
    tick();
    bus.start_i = 1'b0;
    bus.op_i    = MD_NONE;
  endtask

  task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int busy);
    exp_t e;
    e.hi = hi; e.lo = lo; e.busy = busy;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    int   n = 0;
    int   guard = 0;
    exp_t e;
    while (bus.done_o !== 1'b1 && guard < 200) begin
      if (bus.busy_o === 1'b1) n++;
      tick();
      guard++;
    end
    chk({tag, "_done"}, 64'(bus.done_o), 64'd1);
    e = sb_q.pop_front();
    chk({tag, "_hi"}, 64'(bus.hi_o), 64'(e.hi));
    chk({tag, "_lo"}, 64'(bus.lo_o), 64'(e.lo));
    chk({tag, "_busy_cycles"}, 64'(n), 64'(e.busy));
    chk({tag, "_busy_low"}, 64'(bus.busy_o), 64'd0);
    tick();
    chk({tag, "_done_pulse"}, 64'(bus.done_o), 64'd0);
  endtask

  initial begin
    int dones;
    bus.start_i = 1'b0;
    bus.op_i    = MD_NONE;
    bus.src_a_i = '0;
    bus.src_b_i = '0;
    bus.flush_i = 1'b0;

    tick(); tick();
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_done", 64'(bus.done_o), 64'd0);
    chk("rst_hi",   64'(bus.hi_o),   64'd0);
    chk("rst_lo",   64'(bus.lo_o),   64'd0);
    rst_n = 1'b1;
    tick();

    push(32'hFFFF_FFFE, 32'h0000_0001, MUL_BUSY);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max");

    push(32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_BUSY);
    issue(MD_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done("mult_neg");

    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_BUSY);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg");

    push(32'h0000_0000, 32'h8000_0000, DIV_BUSY);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf");

    push(32'h0000_0007, 32'hFFFF_FFFF, DIV_BUSY);
    issue(MD_DIVU, 32'd7, 32'd0);
    wait_done("divu_zero");

    push(32'hFFFF_FFF9, 32'hFFFF_FFFF, DIV_BUSY);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd0);
    wait_done("div_zero_neg");

    // MTHI then MTLO on consecutive cycles
    bus.start_i = 1'b1; bus.op_i = MD_MTHI; bus.src_a_i = 32'h1234;
    tick();
    chk("mthi_hi",   64'(bus.hi_o),   64'h1234);
    chk("mthi_busy", 64'(bus.busy_o), 64'd0);
    bus.op_i = MD_MTLO; bus.src_a_i = 32'hABCD;
    tick();
    bus.start_i = 1'b0; bus.op_i = MD_NONE;
    chk("mtlo_lo",   64'(bus.lo_o),   64'hABCD);
    chk("mtlo_hi",   64'(bus.hi_o),   64'h1234);
    chk("mtlo_busy", 64'(bus.busy_o), 64'd0);
    chk("mtlo_done", 64'(bus.done_o), 64'd0);

    // Flush of an in-flight multiply
    issue(MD_MULTU, 32'd2, 32'd3);
    chk("flush_busy_hi", 64'(bus.busy_o), 64'd1);
    for (int i = 1; i < FLUSH_CYC; i++) tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("flush_busy_low", 64'(bus.busy_o), 64'd0);
    chk("flush_done",     64'(bus.done_o), 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done_o === 1'b1) dones++;
      tick();
    end
    chk("flush_no_done", 64'(dones), 64'd0);
    chk("flush_hi", 64'(bus.hi_o), 64'h1234);
    chk("flush_lo", 64'(bus.lo_o), 64'hABCD);

    // Flush coinciding with an IDLE start suppresses it
    bus.flush_i = 1'b1;
    issue(MD_MTHI, 32'h5555, 32'd0);
    chk("flush_mthi_hi", 64'(bus.hi_o), 64'h1234);
    issue(MD_DIVU, 32'd9, 32'd3);
    bus.flush_i = 1'b0;
    chk("flush_start_busy", 64'(bus.busy_o), 64'd0);
    tick();
    chk("flush_start_busy2", 64'(bus.busy_o), 64'd0);

    // Async reset in the middle of a divide
    issue(MD_DIVU, 32'd1000, 32'd3);
    for (int i = 1; i < 20; i++) tick();
    chk("midrst_busy_before", 64'(bus.busy_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.busy_o), 64'd0);
    chk("midrst_done", 64'(bus.done_o), 64'd0);
    chk("midrst_hi",   64'(bus.hi_o),   64'd0);
    chk("midrst_lo",   64'(bus.lo_o),   64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_busy", 64'(bus.busy_o), 64'd0);

    push(32'd2, 32'd14, DIV_BUSY);
    issue(MD_DIVU, 32'd100, 32'd7);
    wait_done("divu_100_7");

    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
